// File: rtl/truth_table_sweeper_pkg.sv
// Shared types for the truth-table sweeper: FSM state encoding and a counter-width helper.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // A 1-cycle hold still needs a 1-bit counter so the compare stays well-formed.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/result bundle between the sweeper and whoever starts it and watches the DUT.
interface truth_table_sweeper_if #(
  parameter int NVARS = 4
) ();
  import truth_table_sweeper_pkg::*;

  // start is a level request taken only when the sweeper is idle or done; done stays
  // high with pass/err_count/first_err_* stable until the next accepted start or reset.
  logic             start;
  logic             y_in;
  logic [NVARS-1:0] vec_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [NVARS:0]   err_count;
  logic [NVARS-1:0] first_err_idx;
  logic             first_err_vld;
  state_t           state;

  modport master (
    output start, y_in,
    input  vec_out, busy, done, pass, err_count, first_err_idx, first_err_vld, state
  );

  modport slave (
    input  start, y_in,
    output vec_out, busy, done, pass, err_count, first_err_idx, first_err_vld, state
  );

endinterface

// File: rtl/truth_table_sweeper_hold_counter.sv
// Hold-time counter: counts up while enabled, clears on request, flags the last hold cycle.
module truth_table_sweeper_hold_counter
  import truth_table_sweeper_pkg::*;
#(
  parameter int HOLD_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int CW = cnt_width(HOLD_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == CW'(HOLD_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector into a combinational DUT, samples y after a hold time and
// scores it against a constant truth table (bit i of EXPECT is y for vector i).
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int                  NVARS       = 4,
  parameter int                  HOLD_CYCLES = 5,
  parameter logic [2**NVARS-1:0] EXPECT      = '0
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_sweeper_if.slave bus
);

  localparam logic [NVARS-1:0] LAST_IDX = NVARS'(2**NVARS - 1);

  state_t           state;
  logic [NVARS-1:0] idx;
  logic             busy;
  logic             done;
  logic             pass;
  logic [NVARS:0]   err_count;
  logic [NVARS-1:0] first_err_idx;
  logic             first_err_vld;

  logic tc;
  logic mismatch;

  // The counter idles at zero outside DRIVE and restarts each time a vector is sampled.
  truth_table_sweeper_hold_counter #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .clear((state != ST_DRIVE) || tc),
    .en   (state == ST_DRIVE),
    .tc   (tc)
  );

  assign mismatch = (bus.y_in != EXPECT[idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state         <= ST_DRIVE;
            idx           <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (tc) begin
            if (mismatch) begin
              err_count <= err_count + (NVARS+1)'(1);
              if (!first_err_vld) begin
                first_err_idx <= idx;
                first_err_vld <= 1'b1;
              end
            end
            // Terminal index is checked first so idx never wraps back to zero.
            if (idx == LAST_IDX) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !mismatch;
            end else begin
              idx <= idx + NVARS'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vec_out       = idx;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.pass          = pass;
  assign bus.err_count     = err_count;
  assign bus.first_err_idx = first_err_idx;
  assign bus.first_err_vld = first_err_vld;
  assign bus.state         = state;

endmodule
